// File: rtl/ps2_host_tx_if.sv
// Command handshake between the requesting logic and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output tx_data, tx_start, input busy, done, error);
  modport slave  (input tx_data, tx_start, output busy, done, error);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, bit shifting
// on device clock falls, odd parity and ACK check over open-drain lines.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic            CLK100MHZ,
  input  logic            CPU_RESETN,
  ps2_host_tx_if.slave    host,
  input  logic            PS2_CLK_IN,
  input  logic            PS2_DATA_IN,
  output logic            ps2_clk_drive_low,
  output logic            ps2_data_drive_low
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SEND, WAIT_ACK, WAIT_IDLE, DONE, ERR
  } state_t;

  // index 0 = clock line, index 1 = data line
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          clk_prev;
  logic          fall;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1    <= '1;
      sync2    <= '1;
      filt     <= '1;
      fcnt[0]  <= '0;
      fcnt[1]  <= '0;
      clk_prev <= 1'b1;
    end else begin
      sync1    <= {PS2_DATA_IN, PS2_CLK_IN};
      sync2    <= sync1;
      clk_prev <= filt[0];
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall = clk_prev & ~filt[0];

  state_t        state, state_n;
  logic [3:0]    n, n_n, n_inc;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic [IW-1:0] inh_cnt, inh_n;
  logic [TW-1:0] to_cnt, to_n;
  logic          dlow, dlow_n;
  logic          timeout;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state   <= IDLE;
      n       <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      inh_cnt <= '0;
      to_cnt  <= '0;
      dlow    <= 1'b0;
    end else begin
      state   <= state_n;
      n       <= n_n;
      shreg   <= shreg_n;
      par     <= par_n;
      inh_cnt <= inh_n;
      to_cnt  <= to_n;
      dlow    <= dlow_n;
    end
  end

  always_comb begin
    state_n = state;
    n_n     = n;
    shreg_n = shreg;
    par_n   = par;
    inh_n   = inh_cnt;
    to_n    = to_cnt;
    dlow_n  = dlow;
    timeout = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    n_inc   = (n == 4'd11) ? n : n + 4'd1;

    case (state)
      IDLE: begin
        dlow_n = 1'b0;
        if (host.tx_start) begin
          shreg_n = host.tx_data;
          par_n   = ~^host.tx_data;
          n_n     = '0;
          inh_n   = '0;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
          dlow_n  = 1'b1;
          to_n    = '0;
          state_n = REQ;
        end else begin
          inh_n = inh_cnt + 1'b1;
        end
      end
      REQ, SEND, WAIT_ACK, WAIT_IDLE: begin
        // Timeout wins over any fall arriving in the same cycle.
        if (timeout) begin
          dlow_n  = 1'b0;
          state_n = ERR;
        end else begin
          to_n = to_cnt + 1'b1;
          case (state)
            REQ: state_n = SEND;
            SEND: begin
              if (fall) begin
                n_n = n_inc;
                if (n_inc <= 4'd8) begin
                  // Data bits leave LSB first by shifting the latched byte.
                  dlow_n  = ~shreg[0];
                  shreg_n = shreg >> 1;
                end else if (n_inc == 4'd9) begin
                  dlow_n = ~par;
                end else begin
                  dlow_n  = 1'b0;
                  state_n = WAIT_ACK;
                end
              end
            end
            WAIT_ACK: begin
              if (fall) begin
                n_n     = n_inc;
                state_n = filt[1] ? ERR : WAIT_IDLE;
              end
            end
            default: begin
              if (filt[0] && filt[1]) state_n = DONE;
            end
          endcase
        end
      end
      default: begin
        dlow_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign ps2_clk_drive_low  = (state == INHIBIT);
  assign ps2_data_drive_low = dlow && ((state == REQ) || (state == SEND));
  assign host.busy  = (state != IDLE) && (state != DONE) && (state != ERR);
  assign host.done  = (state == DONE);
  assign host.error = (state == ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and its captured frames are compared against frames built from the byte.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int TOUT = 5000;
  localparam int FL   = 2;

  logic CLK100MHZ  = 1'b0;
  logic CPU_RESETN = 1'b0;
  logic dev_clk    = 1'b1;
  logic dev_data   = 1'b1;
  logic PS2_CLK_IN, PS2_DATA_IN;
  logic ps2_clk_drive_low, ps2_data_drive_low;

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  ps2_host_tx_if host_if();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT), .FILTER_LEN(FL)) dut (
    .CLK100MHZ          (CLK100MHZ),
    .CPU_RESETN         (CPU_RESETN),
    .host               (host_if),
    .PS2_CLK_IN         (PS2_CLK_IN),
    .PS2_DATA_IN        (PS2_DATA_IN),
    .ps2_clk_drive_low  (ps2_clk_drive_low),
    .ps2_data_drive_low (ps2_data_drive_low)
  );

  // open-drain wired-AND of host and device
  assign PS2_CLK_IN  = dev_clk  & ~ps2_clk_drive_low;
  assign PS2_DATA_IN = dev_data & ~ps2_data_drive_low;

  always #5 CLK100MHZ = ~CLK100MHZ;

  always @(negedge CLK100MHZ) begin
    if (host_if.done)  done_cnt++;
    if (host_if.error) err_cnt++;
  end

  // frame bit k as seen on the wire: start, 8 data LSB first, odd parity, stop
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2 == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic start_tx(input logic [7:0] b);
    host_if.tx_data  = b;
    host_if.tx_start = 1'b1;
    cyc(1);
    host_if.tx_start = 1'b0;
  endtask

  task automatic wait_not_busy(output bit ok);
    int t;
    t = 0;
    while (host_if.busy && t < 3000) begin cyc(1); t++; end
    ok = !host_if.busy;
    cyc(3);
  endtask

  // Device: waits for request-to-send, then 11 clocks of 40 system cycles,
  // sampling data on each rising edge and optionally pulling ACK low.
  task automatic device_run(input bit ack, input int abort_fall,
                            output bit ok, output logic [10:0] fr);
    int t;
    fr = '0;
    ok = 1'b0;
    t  = 0;
    while (!(ps2_data_drive_low && !ps2_clk_drive_low) && t < 2000) begin cyc(1); t++; end
    if (!(ps2_data_drive_low && !ps2_clk_drive_low)) return;
    cyc(20);
    fr[0] = PS2_DATA_IN;
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == abort_fall) begin cyc(10); ok = 1'b1; return; end
      cyc(20);
      dev_clk = 1'b1;
      if (k <= 10) fr[k] = PS2_DATA_IN;
      if (k == 10 && ack) dev_data = 1'b0;
      if (k == 11) dev_data = 1'b1;
      cyc(20);
    end
    ok = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ack,
                            output bit ok, output logic [10:0] fr);
    start_tx(b);
    device_run(ack, 0, ok, fr);
  endtask

  task automatic test_reset;
    cyc(3);
    tests++;
    if ({host_if.busy, host_if.done, host_if.error, ps2_clk_drive_low, ps2_data_drive_low} !== 5'b0) begin
      fails++;
      $display("FAIL reset_hold: outputs=%b required 00000", {host_if.busy, host_if.done,
               host_if.error, ps2_clk_drive_low, ps2_data_drive_low});
    end
    CPU_RESETN = 1'b1;
    cyc(5);
    tests++;
    if ({host_if.busy, host_if.done, host_if.error, ps2_clk_drive_low, ps2_data_drive_low} !== 5'b0) begin
      fails++;
      $display("FAIL reset_release: outputs=%b required 00000", {host_if.busy, host_if.done,
               host_if.error, ps2_clk_drive_low, ps2_data_drive_low});
    end
  endtask

  task automatic test_send_ed;
    int d0, e0, inh;
    bit ok, nb;
    logic [10:0] fr;
    d0 = done_cnt; e0 = err_cnt; inh = 0;
    start_tx(8'hED);
    fork
      begin
        while (ps2_clk_drive_low && inh < 200) begin inh++; cyc(1); end
      end
      device_run(1'b1, 0, ok, fr);
    join
    tests++;
    if (inh !== INH) begin fails++; $display("FAIL ed_inhibit_len: got %0d cycles required %0d", inh, INH); end
    tests++;
    if (!ok) begin fails++; $display("FAIL ed_req: request seen=%0b required 1", ok); end
    tests++;
    if (fr !== ref_frame(8'hED)) begin fails++; $display("FAIL ed_frame: got %b required %b", fr, ref_frame(8'hED)); end
    wait_not_busy(nb);
    tests++;
    if (!nb) begin fails++; $display("FAIL ed_busy: busy=%b required 0", host_if.busy); end
    tests++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      fails++;
      $display("FAIL ed_pulses: done=%0d error=%0d required 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_parity_f4;
    int d0, e0;
    bit ok, nb;
    logic [10:0] fr;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hF4, 1'b1, ok, fr);
    wait_not_busy(nb);
    tests++;
    if (fr[9] !== 1'b0) begin fails++; $display("FAIL f4_parity: got %b required 0", fr[9]); end
    tests++;
    if (fr !== ref_frame(8'hF4)) begin fails++; $display("FAIL f4_frame: got %b required %b", fr, ref_frame(8'hF4)); end
    tests++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 || !nb) begin
      fails++;
      $display("FAIL f4_pulses: done=%0d error=%0d idle=%0b required 1 0 1", done_cnt - d0, err_cnt - e0, nb);
    end
  endtask

  task automatic test_no_ack;
    int d0, e0;
    bit ok, nb;
    logic [10:0] fr;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hFF, 1'b0, ok, fr);
    wait_not_busy(nb);
    tests++;
    if (fr !== ref_frame(8'hFF)) begin fails++; $display("FAIL noack_frame: got %b required %b", fr, ref_frame(8'hFF)); end
    tests++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      fails++;
      $display("FAIL noack_pulses: error=%0d done=%0d required 1 0", err_cnt - e0, done_cnt - d0);
    end
    tests++;
    if ({ps2_clk_drive_low, ps2_data_drive_low, host_if.busy} !== 3'b000) begin
      fails++;
      $display("FAIL noack_release: clk/data/busy=%b required 000", {ps2_clk_drive_low, ps2_data_drive_low, host_if.busy});
    end
  endtask

  task automatic test_timeout;
    int t, cnt, e0, d0;
    e0 = err_cnt; d0 = done_cnt; t = 0; cnt = 0;
    start_tx(8'h55);
    while (!(ps2_data_drive_low && !ps2_clk_drive_low) && t < 200) begin cyc(1); t++; end
    tests++;
    if (!(ps2_data_drive_low && !ps2_clk_drive_low)) begin
      fails++;
      $display("FAIL timeout_req: request not seen, data_low=%b clk_low=%b", ps2_data_drive_low, ps2_clk_drive_low);
    end
    while (!host_if.error && cnt < 6000) begin cyc(1); cnt++; end
    tests++;
    if (cnt !== TOUT) begin fails++; $display("FAIL timeout_len: error after %0d cycles required %0d", cnt, TOUT); end
    tests++;
    if ({ps2_clk_drive_low, ps2_data_drive_low, host_if.busy} !== 3'b000) begin
      fails++;
      $display("FAIL timeout_release: clk/data/busy=%b required 000", {ps2_clk_drive_low, ps2_data_drive_low, host_if.busy});
    end
    cyc(3);
    tests++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      fails++;
      $display("FAIL timeout_pulses: error=%0d done=%0d required 1 0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_ignore_start;
    int d0;
    bit ok, nb;
    logic [10:0] fr;
    d0 = done_cnt;
    start_tx(8'hED);
    fork
      device_run(1'b1, 0, ok, fr);
      begin
        cyc(300);
        start_tx(8'h00);
      end
    join
    wait_not_busy(nb);
    tests++;
    if (fr !== ref_frame(8'hED)) begin fails++; $display("FAIL ignore_frame: got %b required %b", fr, ref_frame(8'hED)); end
    cyc(50);
    tests++;
    if (host_if.busy !== 1'b0 || done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL ignore_queue: busy=%b done=%0d required 0 1", host_if.busy, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    bit ok, nb;
    logic [10:0] fr;
    start_tx(8'hE5);
    device_run(1'b1, 5, ok, fr);
    tests++;
    if (ps2_data_drive_low !== 1'b1 || host_if.busy !== 1'b1) begin
      fails++;
      $display("FAIL midreset_pre: data_low=%b busy=%b required 1 1", ps2_data_drive_low, host_if.busy);
    end
    #2 CPU_RESETN = 1'b0;
    #1;
    tests++;
    if ({ps2_clk_drive_low, ps2_data_drive_low, host_if.busy} !== 3'b000) begin
      fails++;
      $display("FAIL midreset_async: clk/data/busy=%b required 000", {ps2_clk_drive_low, ps2_data_drive_low, host_if.busy});
    end
    dev_clk = 1'b1;
    cyc(3);
    CPU_RESETN = 1'b1;
    cyc(5);
    d0 = done_cnt;
    send_frame(8'hF4, 1'b1, ok, fr);
    wait_not_busy(nb);
    tests++;
    if (fr !== ref_frame(8'hF4) || done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL midreset_after: frame=%b done=%0d required %b 1", fr, done_cnt - d0, ref_frame(8'hF4));
    end
  endtask

  task automatic test_random;
    int d0, e0;
    bit ok, nb, ack;
    logic [7:0] b;
    logic [10:0] fr;
    for (int i = 0; i < 6; i++) begin
      b   = 8'($urandom_range(0, 255));
      ack = ($urandom_range(0, 3) != 0);
      d0 = done_cnt; e0 = err_cnt;
      send_frame(b, ack, ok, fr);
      wait_not_busy(nb);
      tests++;
      if (fr !== ref_frame(b)) begin fails++; $display("FAIL rand_frame[%0d]: byte %h got %b required %b", i, b, fr, ref_frame(b)); end
      tests++;
      if (done_cnt - d0 !== int'(ack) || err_cnt - e0 !== int'(!ack) || !nb) begin
        fails++;
        $display("FAIL rand_pulses[%0d]: done=%0d error=%0d idle=%0b required %0d %0d 1",
                 i, done_cnt - d0, err_cnt - e0, nb, ack, !ack);
      end
      cyc(10);
    end
  endtask

  initial begin
    host_if.tx_data  = '0;
    host_if.tx_start = 1'b0;
    @(negedge CLK100MHZ);
    test_reset();
    test_send_ed();
    cyc(10);
    test_parity_f4();
    cyc(10);
    test_no_ack();
    cyc(10);
    test_timeout();
    cyc(10);
    test_ignore_start();
    cyc(10);
    test_reset_mid();
    cyc(10);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
